// File: rtl/pictrl_axil_regfile.sv
// AXI4-Lite slave register file for the PI controller: RW gain/setpoint registers,
// RO live-measurement registers and a sticky W1C status register driving irq.
module pictrl_axil_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_NUM_RW           = 8,
  parameter int C_NUM_RO           = 4,
  parameter int C_STS_BITS         = 8
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETN,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  // write response channel
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  // fabric side
  output logic [C_S_AXI_DATA_WIDTH*C_NUM_RW-1:0]   reg_out,
  output logic [C_NUM_RW-1:0]                      wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH*C_NUM_RO-1:0]   ro_in,
  input  logic [C_STS_BITS-1:0]                    sts_set,
  output logic                                     irq
);

  localparam int DW      = C_S_AXI_DATA_WIDTH;
  localparam int SW      = DW / 8;
  localparam int IW      = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STS_IDX = C_NUM_RW + C_NUM_RO;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    REG_RW,
    REG_RO,
    REG_STS,
    REG_BAD
  } reg_class_e;

  function automatic reg_class_e classify(input logic [IW-1:0] idx);
    if (int'(idx) < C_NUM_RW)      return REG_RW;
    else if (int'(idx) < STS_IDX)  return REG_RO;
    else if (int'(idx) == STS_IDX) return REG_STS;
    else                           return REG_BAD;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  aw_held_q, aw_held_d;
  logic [IW-1:0]         aw_idx_q,  aw_idx_d;
  logic                  w_held_q,  w_held_d;
  logic [DW-1:0]         w_data_q,  w_data_d;
  logic [SW-1:0]         w_strb_q,  w_strb_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DW-1:0]         rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic [DW-1:0]         rw_q [C_NUM_RW];
  logic [DW-1:0]         rw_d [C_NUM_RW];
  logic [C_STS_BITS-1:0] sts_q,     sts_d;
  logic                  irq_q,     irq_d;
  logic [C_NUM_RW-1:0]   wr_pulse_q, wr_pulse_d;

  // ---------------------------------------------------------------------------
  // Handshakes and the effective write transaction
  // ---------------------------------------------------------------------------
  logic            aw_hs, w_hs, ar_hs, commit;
  logic [IW-1:0]   wr_idx, rd_idx;
  logic [DW-1:0]   wr_data;
  logic [SW-1:0]   wr_strb;
  reg_class_e      wr_class, rd_class;
  logic [C_STS_BITS-1:0] sts_clr;

  assign S_AXI_AWREADY = !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = !w_held_q  && !bvalid_q;
  assign S_AXI_ARREADY = !rvalid_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A channel handshaking this cycle counts as held, so commit needs no extra cycle.
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
  assign wr_idx  = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
  assign wr_data = w_hs  ? S_AXI_WDATA : w_data_q;
  assign wr_strb = w_hs  ? S_AXI_WSTRB : w_strb_q;
  assign rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  assign wr_class = classify(wr_idx);
  assign rd_class = classify(rd_idx);

  // ---------------------------------------------------------------------------
  // Write path and status next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave a latch.
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rw_d       = rw_q;
    wr_pulse_d = '0;
    sts_clr    = '0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (wr_class == REG_RO || wr_class == REG_BAD) ? RESP_SLVERR : RESP_OKAY;

      for (int k = 0; k < C_NUM_RW; k++) begin
        if (wr_class == REG_RW && int'(wr_idx) == k) begin
          wr_pulse_d[k] = 1'b1;
          for (int b = 0; b < SW; b++) begin
            if (wr_strb[b]) rw_d[k][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end

      if (wr_class == REG_STS) begin
        for (int i = 0; i < C_STS_BITS; i++) begin
          sts_clr[i] = wr_data[i] & wr_strb[i/8];
        end
      end
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Hardware set has priority over a coincident software clear.
    sts_d = (sts_q & ~sts_clr) | sts_set;
    irq_d = |sts_q;
  end

  // ---------------------------------------------------------------------------
  // Read path next state
  // ---------------------------------------------------------------------------
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
      unique case (rd_class)
        REG_RW: begin
          for (int k = 0; k < C_NUM_RW; k++) begin
            if (int'(rd_idx) == k) rdata_d = rw_q[k];
          end
        end
        REG_RO: begin
          for (int k = 0; k < C_NUM_RO; k++) begin
            if (int'(rd_idx) == C_NUM_RW + k) rdata_d = ro_in[DW*k +: DW];
          end
        end
        REG_STS: rdata_d[C_STS_BITS-1:0] = sts_q;
        default: rresp_d = RESP_SLVERR;
      endcase
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      sts_q      <= '0;
      irq_q      <= 1'b0;
      wr_pulse_q <= '0;
      // NOTE: the RW array is a handful of flops feeding live datapath gains, so it is
      // reset like any other register rather than left uninitialised like a RAM.
      for (int k = 0; k < C_NUM_RW; k++) rw_q[k] <= '0;
    end else begin
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      sts_q      <= sts_d;
      irq_q      <= irq_d;
      wr_pulse_q <= wr_pulse_d;
      rw_q       <= rw_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < C_NUM_RW; k++) begin : g_reg_out
    assign reg_out[DW*k +: DW] = rw_q[k];
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign wr_pulse     = wr_pulse_q;
  assign irq          = irq_q;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_pictrl_axil_regfile.sv
// Directed self-checking bench for pictrl_axil_regfile: write/read, split AW/W,
// byte strobes, RO/illegal decode, sticky status with irq, BREADY stall and reset abort.
module tb_pictrl_axil_regfile;

  logic         ACLK;
  logic         ARESETN;
  logic [5:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [5:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [255:0] reg_out;
  logic [7:0]   wr_pulse;
  logic [127:0] ro_in;
  logic [7:0]   sts_set;
  logic         irq;

  int checks   = 0;
  int failures = 0;
  logic [255:0] exp_regs;

  pictrl_axil_regfile dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .reg_out       (reg_out),
    .wr_pulse      (wr_pulse),
    .ro_in         (ro_in),
    .sts_set       (sts_set),
    .irq           (irq)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Present AW and W together, take the handshake edge, check the response appears next cycle.
  task automatic issue_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [7:0] sts_pulse,
                             input logic [1:0] exp_resp, input logic [7:0] exp_pulse,
                             input string tag);
    int n = 0;
    S_AXI_AWADDR  = addr;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_WVALID  = 1'b1;
    sts_set       = sts_pulse;
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    sts_set       = '0;
    check({tag, "_bvalid"}, S_AXI_BVALID, 1'b1);
    check({tag, "_bresp"}, S_AXI_BRESP, exp_resp);
    check({tag, "_pulse"}, wr_pulse, exp_pulse);
  endtask

  task automatic accept_b(input string tag);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check({tag, "_bdone"}, S_AXI_BVALID, 1'b0);
    check({tag, "_pulse_end"}, wr_pulse, 8'h00);
  endtask

  task automatic do_read(input logic [5:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string tag);
    int n = 0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_arready"}, S_AXI_ARREADY, 1'b1);
    tick();
    S_AXI_ARVALID = 1'b0;
    check({tag, "_rvalid"}, S_AXI_RVALID, 1'b1);
    check({tag, "_rdata"}, S_AXI_RDATA, exp_data);
    check({tag, "_rresp"}, S_AXI_RRESP, exp_resp);
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    check({tag, "_rdone"}, S_AXI_RVALID, 1'b0);
  endtask

  initial begin
    ARESETN       = 1'b0;
    S_AXI_AWADDR  = '0;
    S_AXI_AWPROT  = '0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0;
    S_AXI_ARPROT  = '0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    ro_in         = '0;
    sts_set       = '0;

    // Reset state
    repeat (3) tick();
    check("rst_bvalid",  S_AXI_BVALID,  1'b0);
    check("rst_rvalid",  S_AXI_RVALID,  1'b0);
    check("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    check("rst_regs",    reg_out,  256'h0);
    check("rst_pulse",   wr_pulse, 8'h00);
    check("rst_irq",     irq,      1'b0);
    ARESETN = 1'b1;
    tick();

    // Fill every RW register, then read each back
    for (int k = 0; k < 8; k++) begin
      issue_write(6'(4*k), 32'(k+1), 4'hF, 8'h00, 2'b00, 8'(1 << k), $sformatf("fill%0d", k));
      accept_b($sformatf("fill%0d", k));
    end
    for (int k = 0; k < 8; k++) exp_regs[32*k +: 32] = 32'(k+1);
    check("fill_regs", reg_out, exp_regs);
    for (int k = 0; k < 8; k++) do_read(6'(4*k), 32'(k+1), 2'b00, $sformatf("rd%0d", k));

    // W accepted three cycles ahead of AW
    S_AXI_WDATA  = 32'hA5A5A5A5;
    S_AXI_WSTRB  = 4'hF;
    S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    check("wfirst_wready",  S_AXI_WREADY,  1'b0);
    check("wfirst_awready", S_AXI_AWREADY, 1'b1);
    check("wfirst_nobv",    S_AXI_BVALID,  1'b0);
    check("wfirst_noupd",   reg_out[95:64], 32'h00000003);
    tick();
    tick();
    S_AXI_AWADDR  = 6'h08;
    S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    check("wfirst_bvalid", S_AXI_BVALID, 1'b1);
    check("wfirst_bresp",  S_AXI_BRESP,  2'b00);
    check("wfirst_pulse",  wr_pulse,     8'h04);
    check("wfirst_reg2",   reg_out[95:64], 32'hA5A5A5A5);
    accept_b("wfirst");
    exp_regs[95:64] = 32'hA5A5A5A5;
    do_read(6'h08, 32'hA5A5A5A5, 2'b00, "wfirst_rd");

    // Byte strobes
    issue_write(6'h00, 32'h12345678, 4'hF, 8'h00, 2'b00, 8'h01, "full0");
    accept_b("full0");
    issue_write(6'h00, 32'hFFFFFFFF, 4'b0101, 8'h00, 2'b00, 8'h01, "strb0");
    accept_b("strb0");
    check("strb_reg0", reg_out[31:0], 32'h12FF56FF);
    exp_regs[31:0] = 32'h12FF56FF;
    issue_write(6'h04, 32'hFFFFFFFF, 4'b0000, 8'h00, 2'b00, 8'h02, "nostrb1");
    accept_b("nostrb1");
    check("nostrb_regs", reg_out, exp_regs);

    // Read-only and illegal decode; addr[1:0] ignored
    ro_in[31:0]   = 32'hCAFEF00D;
    ro_in[127:96] = 32'h0BADBEEF;
    do_read(6'h20, 32'hCAFEF00D, 2'b00, "ro0");
    do_read(6'h2E, 32'h0BADBEEF, 2'b00, "ro3_off");
    issue_write(6'h20, 32'h11111111, 4'hF, 8'h00, 2'b10, 8'h00, "ro_wr");
    accept_b("ro_wr");
    check("ro_wr_regs", reg_out, exp_regs);
    do_read(6'h20, 32'hCAFEF00D, 2'b00, "ro0_again");
    do_read(6'h3C, 32'h00000000, 2'b10, "bad15");
    do_read(6'h34, 32'h00000000, 2'b10, "bad13");
    do_read(6'h30, 32'h00000000, 2'b00, "sts_empty");

    // Status: set pulse, set-wins race, W1C, irq lag
    sts_set = 8'h05;
    tick();
    sts_set = 8'h00;
    check("irq_lag_set", irq, 1'b0);
    tick();
    check("irq_set", irq, 1'b1);
    do_read(6'h32, 32'h00000005, 2'b00, "sts5");
    issue_write(6'h30, 32'h00000001, 4'hF, 8'h01, 2'b00, 8'h00, "w1c_race");
    accept_b("w1c_race");
    do_read(6'h30, 32'h00000005, 2'b00, "sts_race");
    issue_write(6'h30, 32'h00000005, 4'hF, 8'h00, 2'b00, 8'h00, "w1c_all");
    check("irq_lag_clr", irq, 1'b1);
    accept_b("w1c_all");
    check("irq_clr", irq, 1'b0);
    do_read(6'h30, 32'h00000000, 2'b00, "sts_clr");

    // BREADY stall on an illegal write, then reset mid-hold
    issue_write(6'h38, 32'h22222222, 4'hF, 8'h00, 2'b10, 8'h00, "stall");
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("stall%0d_bv", i),   S_AXI_BVALID, 1'b1);
      check($sformatf("stall%0d_resp", i), S_AXI_BRESP,  2'b10);
      check($sformatf("stall%0d_rdy", i),  {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
    end
    check("stall_regs", reg_out, exp_regs);
    #2;
    ARESETN = 1'b0;
    #1;
    check("abort_bvalid", S_AXI_BVALID, 1'b0);
    check("abort_regs",   reg_out, 256'h0);
    check("abort_bresp",  S_AXI_BRESP, 2'b00);
    S_AXI_BREADY = 1'b1;
    tick();
    ARESETN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("post%0d_bv", i), S_AXI_BVALID, 1'b0);
    end
    S_AXI_BREADY = 1'b0;
    check("post_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    do_read(6'h08, 32'h00000000, 2'b00, "post_rd2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
